// File: rtl/blink_pkg.sv
// blink_pkg: shared types and defaults for the LED blink sequencer
//   DEF_CNT_W : default width of the per-channel period / tick counter
//   CFG_W     : carrier width for the channel index and period inside cfg_t
//   state_t   : sequencer state (IDLE / RUN)
//   cfg_t     : one channel configuration request {ch, en, period}
package blink_pkg;
    localparam int DEF_CNT_W = 16;
    localparam int CFG_W = 32;
    typedef enum logic {IDLE, RUN} state_t;
    typedef struct packed {
        logic [CFG_W-1:0] ch;
        logic             en;
        logic [CFG_W-1:0] period;
    } cfg_t;
endpackage

// File: rtl/blink_channel.sv
// blink_channel: one LED toggle channel driven by the shared tick
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   tick   : one-cycle prescaler pulse; advances the channel counter
//   commit : a pending config is being applied this edge (any channel)
//   cfg    : the config being committed; applied only when cfg.ch == IDX
//   toggle : square-wave output, flips every 'period' ticks
module blink_channel
    import blink_pkg::*;
#(
    parameter int IDX = 0,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic commit,
    input  cfg_t cfg,
    output logic toggle
);
    logic             en;
    logic [CFG_W-1:0] period;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    logic             active;
    logic             wrap;

    assign hit = commit && cfg.ch == CFG_W'(IDX);
    assign active = tick && en && period != '0;
    assign wrap = CFG_W'(cnt) == period - CFG_W'(1);

    // A commit to this channel overrides a same-edge tick update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en     <= 1'b0;
            period <= '0;
            cnt    <= '0;
            toggle <= 1'b1;
        end else if (hit) begin
            en     <= cfg.en;
            period <= cfg.period;
            cnt    <= '0;
            toggle <= 1'b1;
        end else if (active) begin
            cnt    <= wrap ? '0 : cnt + CNT_W'(1);
            toggle <= toggle ^ wrap;
        end
    end
endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: shared-timebase controller for N_CH LED toggle channels
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   run        : 1 = sequencing active, 0 = paused
//   cfg_valid  : config request valid
//   cfg_ready  : config slot free (registered, independent of cfg_valid)
//   cfg_ch     : target channel; indices >= N_CH are accepted and discarded
//   cfg_en     : channel enable
//   cfg_period : half-period in ticks; 0 freezes the channel
//   tick       : one-cycle pulse at prescaler wrap
//   busy       : 1 while in RUN
//   toggle     : per-channel square-wave outputs
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int PRESCALE = 4_000_000,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [$clog2(N_CH):0] cfg_ch,
    input  logic                  cfg_en,
    input  logic [CNT_W-1:0]      cfg_period,
    output logic                  tick,
    output logic                  busy,
    output logic [N_CH-1:0]       toggle
);
    localparam int PRE_W = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    state_t           state;
    state_t           state_nx;
    logic [PRE_W-1:0] pre;
    logic             full;
    logic             hold;
    logic             commit;
    cfg_t             slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = run ? RUN : IDLE;
    end

    always_comb begin
        busy = state == RUN;
        tick = busy && pre == PRE_MAX;
    end

    // Prescaler only runs while staying in RUN; leaving RUN clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre <= '0;
        else      pre <= (busy && run) ? (tick ? '0 : pre + PRE_W'(1)) : '0;
    end

    // hold keeps cfg_ready low for the cycle right after a commit.
    assign cfg_ready = !full && !hold;
    assign commit = full && (!busy || tick);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            hold <= 1'b0;
            slot <= '0;
        end else begin
            hold <= commit;
            full <= commit ? 1'b0 : (full || (cfg_valid && cfg_ready));
            if (cfg_valid && cfg_ready)
                slot <= '{ch: CFG_W'(cfg_ch), en: cfg_en, period: CFG_W'(cfg_period)};
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        blink_channel #(.IDX(i), .CNT_W(CNT_W)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .commit (commit),
            .cfg    (slot),
            .toggle (toggle[i])
        );
    end
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: directed + randomized check of blink_sequencer against a behavioural model
module tb_blink_sequencer;
    localparam int P = 4;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         run = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_en = 1'b0;
    logic [2:0]   cfg_ch = '0;
    logic [W-1:0] cfg_period = '0;
    logic         cfg_ready;
    logic         tick;
    logic         busy;
    logic [N-1:0] toggle;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    blink_sequencer #(.N_CH(N), .PRESCALE(P), .CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_en     (cfg_en),
        .cfg_period (cfg_period),
        .tick       (tick),
        .busy       (busy),
        .toggle     (toggle)
    );

    // Model: RUN-cycle count gives tick phase; each channel counts active ticks
    // since its last commit, and its toggle is 1 while floor(ticks/period) is even.
    typedef struct {int ch; bit en; int per;} req_t;
    req_t pend[$];
    bit   m_busy = 1'b0;
    bit   m_hold = 1'b0;
    bit   tk;
    bit   cm;
    bit   rdy;
    int   m_rc = 0;
    bit   m_en[N];
    int   m_per[N];
    int   m_ticks[N];

    function automatic logic [N-1:0] exp_tog();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++)
            v[c] = (m_per[c] == 0) ? 1'b1 : (((m_ticks[c] / m_per[c]) % 2) == 0);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 1'b0;
            m_hold = 1'b0;
            m_rc = 0;
            pend.delete();
            for (int c = 0; c < N; c++) begin
                m_en[c] = 1'b0;
                m_per[c] = 0;
                m_ticks[c] = 0;
            end
        end else begin
            tk = m_busy && (m_rc % P == P - 1);
            rdy = pend.size() == 0 && !m_hold;
            cm = pend.size() != 0 && (!m_busy || tk);
            for (int c = 0; c < N; c++) begin
                if (cm && pend[0].ch == c) begin
                    m_en[c] = pend[0].en;
                    m_per[c] = pend[0].per;
                    m_ticks[c] = 0;
                end else if (tk && m_en[c] && m_per[c] != 0) begin
                    m_ticks[c]++;
                end
            end
            if (cm) void'(pend.pop_front());
            if (cfg_valid && rdy) pend.push_back('{int'(cfg_ch), cfg_en, int'(cfg_period)});
            m_hold = cm;
            m_rc = (m_busy && run) ? m_rc + 1 : 0;
            m_busy = run;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("tick", 32'(tick), 32'(m_busy && (m_rc % P == P - 1)));
            check("busy", 32'(busy), 32'(m_busy));
            check("cfg_ready", 32'(cfg_ready), 32'(pend.size() == 0 && !m_hold));
            check("toggle", 32'(toggle), 32'(exp_tog()));
            check("ready_while_full", 32'(pend.size() != 0 && cfg_ready), 32'd0);
            check("tick_in_idle", 32'(tick && !busy), 32'd0);
        end
    end

    task automatic send(input int ch, input bit en, input int per);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_ch = 3'(ch);
        cfg_en = en;
        cfg_period = W'(per);
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ready=%0b after %0d cycles, required 1", cfg_ready, n);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int r;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // IDLE config: ready low for two cycles, then run
        send(0, 1'b1, 2);
        check("t2_ready_a", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        check("t2_ready_b", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        check("t2_ready_c", 32'(cfg_ready), 32'd1);
        run = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 3) check("t2_tick3", 32'(tick), 32'd0);
            if (k == 4) check("t2_tick4", 32'(tick), 32'd1);
            if (k == 8) check("t2_tog_k8", 32'(toggle[0]), 32'd1);
            if (k == 9) check("t2_tog_k9", 32'(toggle[0]), 32'd0);
        end
        // RUN mid-period config: commit lands on the next tick
        @(negedge clk);
        send(1, 1'b1, 3);
        cnt = 0;
        while (!tick && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("t3_tick_seen", 32'(tick), 32'd1);
        @(negedge clk);
        check("t3_commit_tog", 32'(toggle[1]), 32'd1);
        repeat (11) @(negedge clk);
        check("t3_tog_c11", 32'(toggle[1]), 32'd1);
        @(negedge clk);
        check("t3_tog_c12", 32'(toggle[1]), 32'd0);
        // frozen channel: period 0
        send(2, 1'b1, 0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tick) cnt++;
            if (toggle[2] !== 1'b1) check("t4_frozen", 32'(toggle[2]), 32'd1);
        end
        check("t4_frozen_end", 32'(toggle[2]), 32'd1);
        check("t4_ticks", 32'(cnt), 32'd10);
        // out-of-range channel is swallowed
        send(5, 1'b1, 1);
        repeat (6) @(negedge clk);
        check("t5_ch3_idle", 32'(toggle[3]), 32'd1);
        check("t5_ch2_frozen", 32'(toggle[2]), 32'd1);
        // pause and resume
        run = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        check("t6_pause_ticks", 32'(cnt), 32'd0);
        check("t6_pause_busy", 32'(busy), 32'd0);
        run = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t6_first_tick", 32'(tick), 32'(k == 4));
        end
        // async reset between edges while running
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t1_toggle", 32'(toggle), 32'hF);
        check("t1_tick", 32'(tick), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                run = ~run;
                @(negedge clk);
            end else if (r < 4) begin
                send(int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, int'($urandom_range(0, 4)));
            end else begin
                @(negedge clk);
            end
        end
        run = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
